// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multi-cycle multiply/divide sequencer that owns HI/LO.
// A mult/multu/div/divu in E is accepted while idle. The result is computed
// at the accept edge and parked in pending registers. It is committed to
// HI/LO after the configured number of busy cycles. mthi/mtlo write
// directly while idle. A stall request holds MDU-touching instructions in D.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   op_e       in   [2:0] E-stage MDU op (0 none, 1 mult, 2 multu, 3 div,
//                   4 divu, 5 mthi, 6 mtlo, 7 reserved/none)
//   rs_e       in   [31:0] forwarded rs value in E
//   rt_e       in   [31:0] forwarded rt value in E
//   md_use_d   in   D-stage instruction uses the MDU
//   hi         out  [31:0] committed HI
//   lo         out  [31:0] committed LO
//   busy       out  countdown in progress
//   start      out  combinational, a mult/div is being accepted this cycle
//   stall_req  out  combinational, md_use_d && (busy || start)
module mdu_scheduler #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  op_e,
   input  logic [31:0] rs_e,
   input  logic [31:0] rt_e,
   input  logic        md_use_d,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        start,
   output logic        stall_req
);

   localparam int unsigned DW      = 32;
   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [DW-1:0]      hi_q, lo_q;
   logic [DW-1:0]      pend_hi_q, pend_lo_q;

   logic               is_mul, is_div, is_signed;
   logic [2*DW-1:0]    mul_a, mul_b, product;
   logic [DW-1:0]      a_mag, b_mag, q_mag, r_mag;
   logic [DW-1:0]      res_hi_d, res_lo_d;

   // Op decode and accept strobe
   always_comb begin
      is_mul    = (op_e == OP_MULT) || (op_e == OP_MULTU);
      is_div    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
      is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
   end

   assign start     = (state_q == S_IDLE) && (is_mul || is_div);
   assign stall_req = md_use_d && (busy || start);
   assign busy      = (state_q == S_RUN);
   assign hi        = hi_q;
   assign lo        = lo_q;

   // Result datapath. Division works on magnitudes so the signed overflow
   // case (0x8000_0000 / -1) falls out naturally as quotient 0x8000_0000.
   always_comb begin
      mul_a    = {{DW{is_signed & rs_e[DW-1]}}, rs_e};
      mul_b    = {{DW{is_signed & rt_e[DW-1]}}, rt_e};
      product  = mul_a * mul_b;

      a_mag    = (is_signed && rs_e[DW-1]) ? (DW'(0) - rs_e) : rs_e;
      b_mag    = (is_signed && rt_e[DW-1]) ? (DW'(0) - rt_e) : rt_e;
      q_mag    = '0;
      r_mag    = '0;
      if (b_mag != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end

      res_hi_d = product[2*DW-1:DW];
      res_lo_d = product[DW-1:0];
      if (is_div) begin
         if (rt_e == '0) begin
            res_lo_d = '1;
            res_hi_d = rs_e;
         end else begin
            res_lo_d = (is_signed && (rs_e[DW-1] ^ rt_e[DW-1])) ? (DW'(0) - q_mag) : q_mag;
            res_hi_d = (is_signed && rs_e[DW-1]) ? (DW'(0) - r_mag) : r_mag;
         end
      end
   end

   // Sequencer: accept, countdown, commit; ops arriving during RUN are ignored
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pend_hi_q <= res_hi_d;
                  pend_lo_q <= res_lo_d;
                  cnt_q     <= is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                  state_q   <= S_RUN;
               end else if (op_e == OP_MTHI) begin
                  hi_q <= rs_e;
               end else if (op_e == OP_MTLO) begin
                  lo_q <= rs_e;
               end
            end
            S_RUN: begin
               if (cnt_q == '0) begin
                  hi_q    <= pend_hi_q;
                  lo_q    <= pend_lo_q;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler with hand-computed HI/LO results.
module tb_mdu_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  op_e;
   logic [31:0] rs_e, rt_e;
   logic        md_use_d;
   logic [31:0] hi, lo;
   logic        busy, start, stall_req;

   int checks = 0;
   int errors = 0;

   mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_e      (op_e),
      .rs_e      (rs_e),
      .rt_e      (rt_e),
      .md_use_d  (md_use_d),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .start     (start),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one mult/div, walk the busy window, then check the commit.
   // A stray mult is driven mid-run to confirm it is ignored.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic md, input int n,
                         input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      op_e = op; rs_e = a; rt_e = b; md_use_d = md;
      #1;
      chk({tag, "_start"}, 32'(start), 32'd1);
      chk({tag, "_stall_start"}, 32'(stall_req), 32'(md));
      step();
      for (int i = 0; i < n; i++) begin
         op_e = (i == 2) ? 3'd1 : 3'd0;
         rs_e = 32'h0BAD_0BAD; rt_e = 32'h0000_0003;
         #1;
         chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
         chk($sformatf("%s_nostart%0d", tag, i), 32'(start), 32'd0);
         chk($sformatf("%s_stall%0d", tag, i), 32'(stall_req), 32'(md));
         chk($sformatf("%s_oldhi%0d", tag, i), hi, old_hi);
         chk($sformatf("%s_oldlo%0d", tag, i), lo, old_lo);
         step();
      end
      op_e = 3'd0;
      #1;
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_stall_end"}, 32'(stall_req), 32'd0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      md_use_d = 1'b0;
   endtask

   initial begin
      reset = 1'b1; op_e = 3'd0; rs_e = '0; rt_e = '0; md_use_d = 1'b0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);

      // -2 * 3 = -6
      run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 5,
             32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      step();
      // -7 / 2 signed: q=-3, r=-1
      run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      step();
      // 0xFFFFFFF9 / 2 unsigned
      run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);
      step();
      run_op("divu0", 3'd4, 32'h0000_1234, 32'd0, 1'b0, 10,
             32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_1234, 32'hFFFF_FFFF);
      step();
      run_op("div0", 3'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 10,
             32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      step();
      run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10,
             32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      // Back-to-back re-accept on the first idle edge, with stall
      run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,
             32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0000_0001);

      // mthi / mtlo on consecutive edges
      op_e = 3'd5; rs_e = 32'hDEAD_BEEF; md_use_d = 1'b1;
      #1;
      chk("mthi_start", 32'(start), 32'd0);
      chk("mthi_stall", 32'(stall_req), 32'd0);
      step();
      chk("mthi_hi", hi, 32'hDEAD_BEEF);
      chk("mthi_lo", lo, 32'h0000_0001);
      chk("mthi_busy", 32'(busy), 32'd0);
      op_e = 3'd6; rs_e = 32'h0000_0001;
      step();
      chk("mtlo_hi", hi, 32'hDEAD_BEEF);
      chk("mtlo_lo", lo, 32'h0000_0001);
      chk("mtlo_busy", 32'(busy), 32'd0);

      // Reserved op is a no-op
      op_e = 3'd7; rs_e = 32'h5555_5555;
      #1;
      chk("rsv_start", 32'(start), 32'd0);
      step();
      chk("rsv_busy", 32'(busy), 32'd0);
      chk("rsv_hi", hi, 32'hDEAD_BEEF);
      chk("rsv_lo", lo, 32'h0000_0001);
      md_use_d = 1'b0;

      // Reset during busy cycle 4 cancels the divide
      op_e = 3'd3; rs_e = 32'd100; rt_e = 32'd7;
      step();
      op_e = 3'd0;
      for (int i = 1; i < 4; i++) begin
         chk($sformatf("cancel_busy%0d", i), 32'(busy), 32'd1);
         step();
      end
      chk("cancel_busy4", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("cancel_busy", 32'(busy), 32'd0);
      chk("cancel_hi", hi, 32'h0);
      chk("cancel_lo", lo, 32'h0);
      for (int i = 0; i < 12; i++) step();
      chk("cancel_late_busy", 32'(busy), 32'd0);
      chk("cancel_late_hi", hi, 32'h0);
      chk("cancel_late_lo", lo, 32'h0);

      // Fresh mult after reset: 7 * 6
      run_op("mult_post", 3'd1, 32'd7, 32'd6, 1'b1, 5,
             32'h0, 32'h0, 32'h0, 32'h0000_002A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
